// File: rtl/fs2_misfetch_ctrl.sv
// Fetch-2 misfetch recovery: redirects fetch-1 when the pre-decoded next PC disagrees
// with the BTB path, and queues BTB corrections. Optional macro: FS2_BTB_INVAL_EN.
module fs2_misfetch_ctrl #(
    parameter int SIZE_PC     = 32,
    parameter int BRANCH_TYPE = 2,
    parameter int QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [SIZE_PC-1:0]     pc_i,
    input  logic                   btbHit_i,
    input  logic [SIZE_PC-1:0]     btbNPC_i,
    input  logic                   ctrlInst_i,
    input  logic [SIZE_PC-1:0]     predNPC_i,
    input  logic [BRANCH_TYPE-1:0] ctrlType_i,
    output logic                   stall_o,
    output logic                   squash_o,
    output logic                   redirect_o,
    output logic [SIZE_PC-1:0]     redirectPC_o,
    output logic                   btbUpdValid_o,
    input  logic                   btbUpdReady_i,
    output logic [SIZE_PC-1:0]     btbUpdPC_o,
    output logic [SIZE_PC-1:0]     btbUpdTarget_o,
    output logic [BRANCH_TYPE-1:0] btbUpdType_o,
    output logic                   btbUpdInval_o
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        SQUASH
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [SIZE_PC-1:0]     pc_mem     [QDEPTH];
    logic [SIZE_PC-1:0]     target_mem [QDEPTH];
    logic [BRANCH_TYPE-1:0] type_mem   [QDEPTH];

    logic                   evaluate;
    logic                   ctrl_mis;
    logic                   nonctrl_mis;
    logic                   misfetch;
    logic [SIZE_PC-1:0]     correct_pc;
    logic                   push;
    logic                   pop;

    assign stall_o       = (count == FULL_CNT);
    assign btbUpdValid_o = (count != '0);
    assign pop           = btbUpdValid_o & btbUpdReady_i;

    assign evaluate    = valid_i & ~stall_o & ~flush_i & (state == IDLE);
    assign ctrl_mis    = ctrlInst_i & (predNPC_i != btbNPC_i);
    assign nonctrl_mis = ~ctrlInst_i & btbHit_i;
    assign misfetch    = evaluate & (ctrl_mis | nonctrl_mis);
    assign correct_pc  = ctrlInst_i ? predNPC_i : (pc_i + SIZE_PC'(8));

`ifdef FS2_BTB_INVAL_EN
    logic inval_mem [QDEPTH];

    assign push          = misfetch;
    assign btbUpdInval_o = inval_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inval_mem[i] <= 1'b0;
            end
        end else if (push) begin
            inval_mem[wr_ptr] <= ~ctrlInst_i;
        end
    end
`else
    // Non-control BTB hits still redirect, but training them would need invalidation.
    assign push          = misfetch & ctrlInst_i;
    assign btbUpdInval_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = misfetch ? REDIR : IDLE;
                REDIR:   next_state = SQUASH;
                SQUASH:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        squash_o = 1'b0;
        case (state)
            REDIR, SQUASH: squash_o = 1'b1;
            default:       squash_o = 1'b0;
        endcase
    end

    // misfetch already excludes flush, so a flush clears the pulse on the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_o   <= 1'b0;
            redirectPC_o <= '0;
        end else begin
            redirect_o <= misfetch;
            if (misfetch) begin
                redirectPC_o <= correct_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem[i]     <= '0;
                target_mem[i] <= '0;
                type_mem[i]   <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]     <= pc_i;
            target_mem[wr_ptr] <= correct_pc;
            type_mem[wr_ptr]   <= ctrlType_i;
        end
    end

    assign btbUpdPC_o     = pc_mem[rd_ptr];
    assign btbUpdTarget_o = target_mem[rd_ptr];
    assign btbUpdType_o   = type_mem[rd_ptr];

endmodule
